// File: rtl/histogram_rmw_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : histogram_rmw_sched_if
// Brief    : Start/status and image/bin RAM port bundle for histogram_rmw_sched.
// Revision : 1.0
// ============================================================================
interface histogram_rmw_sched_if #(
   parameter int IMG_AW = 12,
   parameter int CNT_W  = 32
) ();
   logic              start;
   logic [IMG_AW:0]   len;
   logic              busy;
   logic              done;
   logic [IMG_AW-1:0] img_raddr;
   logic [7:0]        img_rdata;
   logic [7:0]        bin_raddr;
   logic [CNT_W-1:0]  bin_rdata;
   logic [7:0]        bin_waddr;
   logic [CNT_W-1:0]  bin_wdata;
   logic              bin_wen;

   // Side that requests the operation and hosts both RAMs
   modport master (
      output start, len, img_rdata, bin_rdata,
      input  busy, done, img_raddr, bin_raddr, bin_waddr, bin_wdata, bin_wen
   );

   // The histogram engine
   modport slave (
      input  start, len, img_rdata, bin_rdata,
      output busy, done, img_raddr, bin_raddr, bin_waddr, bin_wdata, bin_wen
   );
endinterface
`default_nettype wire

// File: rtl/histogram_rmw_sched.sv
`default_nettype none
// ============================================================================
// Module   : histogram_rmw_sched
// Brief    : Three-stage read-modify-write histogram engine over an image RAM.
//            HIST_RMW_FWD_EN: forward on bin hazards, otherwise stall one cycle.
// Revision : 1.0
// ============================================================================
module histogram_rmw_sched #(
   parameter int IMG_AW = 12,
   parameter int CNT_W  = 32
) (
   input wire clk,
   input wire rst,
   histogram_rmw_sched_if.slave bus
);
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   logic [1:0]        r_state;
   logic              r_s0_vld;
   logic [IMG_AW-1:0] r_s0_addr;
   logic [IMG_AW:0]   r_rem;
   logic              r_s1_vld;
   logic              r_s2_vld;
   logic [7:0]        r_s2_pix;

   logic [7:0]        w_s1_pix;
   logic              w_hazard;
   logic              w_stall;
   logic [CNT_W-1:0]  w_base;
   logic [CNT_W-1:0]  w_wdata;
   logic              w_last_wr;

   assign w_hazard  = r_s1_vld & r_s2_vld & (w_s1_pix == r_s2_pix);
   assign w_wdata   = w_base + CNT_W'(1);
   assign w_last_wr = r_s2_vld & ~r_s1_vld & ~r_s0_vld;

`ifdef HIST_RMW_FWD_EN
   logic             r_fwd_vld;
   logic [CNT_W-1:0] r_fwd_val;

   assign w_s1_pix = bus.img_rdata;
   assign w_stall  = 1'b0;
   // The bin read issued alongside a same-bin write returned stale data
   assign w_base   = r_fwd_vld ? r_fwd_val : bus.bin_rdata;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_fwd_vld <= 1'b0;
         r_fwd_val <= '0;
      end else begin
         r_fwd_vld <= w_hazard;
         r_fwd_val <= w_wdata;
      end
   end
`else
   logic       r_s1_hold;
   logic [7:0] r_s1_pix;

   // During the replay cycle img_rdata belongs to the held S0 address
   assign w_s1_pix = r_s1_hold ? r_s1_pix : bus.img_rdata;
   assign w_stall  = w_hazard;
   assign w_base   = bus.bin_rdata;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_s1_hold <= 1'b0;
         r_s1_pix  <= '0;
      end else begin
         r_s1_hold <= w_stall;
         r_s1_pix  <= w_s1_pix;
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state   <= ST_IDLE;
         r_s0_vld  <= 1'b0;
         r_s0_addr <= '0;
         r_rem     <= '0;
         r_s1_vld  <= 1'b0;
         r_s2_vld  <= 1'b0;
         r_s2_pix  <= '0;
      end else begin
         r_s2_vld <= r_s1_vld & ~w_stall;
         r_s2_pix <= w_s1_pix;
         if (!w_stall) begin
            r_s1_vld <= r_s0_vld;
         end
         case (r_state)
            ST_IDLE: begin
               if (bus.start) begin
                  if (bus.len != '0) begin
                     r_state   <= ST_RUN;
                     r_s0_vld  <= 1'b1;
                     r_s0_addr <= '0;
                     r_rem     <= bus.len;
                  end else begin
                     r_state <= ST_DONE;
                  end
               end
            end
            ST_RUN: begin
               if (!w_stall) begin
                  r_rem <= r_rem - (IMG_AW+1)'(1);
                  // Address is not advanced past the last pixel, so len=2^IMG_AW never wraps
                  if (r_rem == (IMG_AW+1)'(1)) begin
                     r_s0_vld <= 1'b0;
                     r_state  <= ST_DRAIN;
                  end else begin
                     r_s0_addr <= r_s0_addr + IMG_AW'(1);
                  end
               end
            end
            ST_DRAIN: begin
               if (w_last_wr) begin
                  r_state <= ST_DONE;
               end
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.busy      = (r_state == ST_RUN) | (r_state == ST_DRAIN);
   assign bus.done      = (r_state == ST_DONE);
   assign bus.img_raddr = r_s0_vld ? r_s0_addr : '0;
   assign bus.bin_raddr = r_s1_vld ? w_s1_pix : '0;
   assign bus.bin_waddr = r_s2_vld ? r_s2_pix : '0;
   assign bus.bin_wdata = r_s2_vld ? w_wdata : '0;
   assign bus.bin_wen   = r_s2_vld;
endmodule
`default_nettype wire
